// File: rtl/cdb_arbiter_if.sv
// CDB arbiter bus bundle: three result producers on one side, CDB broadcast on the other.
// Latency: none (wires only).
// Backpressure: per-source src_ready; the broadcast side is never stalled.
// Ports: flush, src_valid/src_ready, srcN_tag/srcN_data in; cdb_valid/tag/data/src out.
// master = producers and CDB snoopers, slave = arbiter.
interface cdb_arbiter_if #(
   parameter int ROB_IDX_W = 3
);
   logic                 flush;
   logic [2:0]           src_valid;
   logic [2:0]           src_ready;
   logic [ROB_IDX_W-1:0] src0_tag;
   logic [ROB_IDX_W-1:0] src1_tag;
   logic [ROB_IDX_W-1:0] src2_tag;
   logic [31:0]          src0_data;
   logic [31:0]          src1_data;
   logic [31:0]          src2_data;
   logic                 cdb_valid;
   logic [ROB_IDX_W-1:0] cdb_tag;
   logic [31:0]          cdb_data;
   logic [1:0]           cdb_src;

   modport master (
      output flush, src_valid, src0_tag, src1_tag, src2_tag,
             src0_data, src1_data, src2_data,
      input  src_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
   );

   modport slave (
      input  flush, src_valid, src0_tag, src1_tag, src2_tag,
             src0_data, src1_data, src2_data,
      output src_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
   );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin share of the common data bus between ALU (0), branch unit (1) and LSQ (2).
// Latency: 2 edges from accept to cdb_valid, plus one cycle per lost arbitration.
// Backpressure: src_ready drops while a source's one-entry buffer is full and not draining.
// Ports: clk, rst_n (async, active low), bus (slave modport of cdb_arbiter_if).
module cdb_arbiter #(
   parameter int ROB_IDX_W = 3
) (
   input logic          clk,
   input logic          rst_n,
   cdb_arbiter_if.slave bus
);

   logic [2:0]           buf_vld;
   logic [ROB_IDX_W-1:0] buf_tag  [3];
   logic [31:0]          buf_data [3];
   logic [1:0]           last_grant;

   logic [ROB_IDX_W-1:0] in_tag  [3];
   logic [31:0]          in_data [3];
   logic [2:0]           grant;
   logic [1:0]           win;
   logic [1:0]           ord [3];
   logic [2:0]           xfer;

   assign in_tag[0]  = bus.src0_tag;
   assign in_tag[1]  = bus.src1_tag;
   assign in_tag[2]  = bus.src2_tag;
   assign in_data[0] = bus.src0_data;
   assign in_data[1] = bus.src1_data;
   assign in_data[2] = bus.src2_data;

   // Search order starts one past the previous winner, so the previous winner is last.
   // Walking the order backwards lets the highest-priority hit be the final assignment.
   always_comb begin
      ord   = '{2'd0, 2'd1, 2'd2};
      grant = 3'b000;
      win   = 2'd0;
      case (last_grant)
         2'd0:    ord = '{2'd1, 2'd2, 2'd0};
         2'd1:    ord = '{2'd2, 2'd0, 2'd1};
         default: ord = '{2'd0, 2'd1, 2'd2};
      endcase
      if (!bus.flush) begin
         for (int k = 2; k >= 0; k--) begin
            if (buf_vld[ord[k]]) begin
               grant = 3'b001 << ord[k];
               win   = ord[k];
            end
         end
      end
   end

   // A draining buffer accepts in the same cycle; rst_n gating keeps ready low in reset.
   assign bus.src_ready = {3{rst_n & ~bus.flush}} & (~buf_vld | grant);
   assign xfer          = bus.src_valid & bus.src_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_vld       <= 3'b000;
         last_grant    <= 2'd2;
         bus.cdb_valid <= 1'b0;
         bus.cdb_tag   <= '0;
         bus.cdb_data  <= '0;
         bus.cdb_src   <= 2'd0;
         for (int i = 0; i < 3; i++) begin
            buf_tag[i]  <= '0;
            buf_data[i] <= '0;
         end
      end else if (bus.flush) begin
         // Everything buffered or about to broadcast is wrong-path; last_grant keeps fairness.
         buf_vld       <= 3'b000;
         bus.cdb_valid <= 1'b0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (xfer[i]) begin
               // Refill wins over drain: buffer stays valid with the new payload.
               buf_vld[i]  <= 1'b1;
               buf_tag[i]  <= in_tag[i];
               buf_data[i] <= in_data[i];
            end else if (grant[i]) begin
               buf_vld[i] <= 1'b0;
            end
         end
         bus.cdb_valid <= |grant;
         if (|grant) begin
            bus.cdb_tag  <= buf_tag[win];
            bus.cdb_data <= buf_data[win];
            bus.cdb_src  <= win;
            last_grant   <= win;
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: stimulus pushes expected broadcasts, a monitor pops them.
module tb_cdb_arbiter;
   localparam int W = 3;
   localparam int EW = W + 34;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cdb_arbiter_if #(.ROB_IDX_W(W)) bus ();

   cdb_arbiter #(.ROB_IDX_W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_vec = 0;
   int n_bad = 0;
   logic [EW-1:0] exp_q [$];
   logic [2:0] rdy_tab [7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [EW-1:0] ent(input logic [W-1:0] tag, input logic [31:0] d,
                                         input logic [1:0] s);
      return {tag, d, s};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      bus.src_valid = 3'b000;
      bus.flush     = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   // Monitor: every broadcast must match the oldest expected entry.
   always @(negedge clk) begin
      logic [EW-1:0] e;
      if (rst_n && bus.cdb_valid) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_bcast: got tag %0h data %0h src %0d, expected no broadcast",
                     bus.cdb_tag, bus.cdb_data, bus.cdb_src);
         end else begin
            e = exp_q.pop_front();
            chk("cdb_bcast", 64'({bus.cdb_tag, bus.cdb_data, bus.cdb_src}), 64'(e));
         end
      end
   end

   initial begin
      logic [2:0] smp;
      int k [3];

      rdy_tab[0] = 3'b111; rdy_tab[1] = 3'b001; rdy_tab[2] = 3'b010; rdy_tab[3] = 3'b100;
      rdy_tab[4] = 3'b001; rdy_tab[5] = 3'b010; rdy_tab[6] = 3'b100;

      bus.flush = 1'b0;
      bus.src_valid = 3'b000;
      bus.src0_tag = '0; bus.src1_tag = '0; bus.src2_tag = '0;
      bus.src0_data = '0; bus.src1_data = '0; bus.src2_data = '0;

      // Reset state
      #12;
      chk("rst_cdb_valid", 64'(bus.cdb_valid), 64'd0);
      chk("rst_cdb_tag",   64'(bus.cdb_tag),   64'd0);
      chk("rst_cdb_data",  64'(bus.cdb_data),  64'd0);
      chk("rst_cdb_src",   64'(bus.cdb_src),   64'd0);
      chk("rst_src_ready", 64'(bus.src_ready), 64'd0);
      rst_n = 1'b1;
      step();

      // Single result from source 0
      bus.src_valid = 3'b001; bus.src0_tag = 3'd5; bus.src0_data = 32'h0000_00AA;
      exp_q.push_back(ent(3'd5, 32'hAA, 2'd0));
      @(negedge clk);
      chk("single_ready0", 64'(bus.src_ready[0]), 64'd1);
      step();
      idle(4);

      // Full contention from a fresh reset: order 0,1,2 repeating
      #2 rst_n = 1'b0;
      #4 rst_n = 1'b1;
      step();
      for (int r = 0; r < 3; r++)
         for (int s = 0; s < 3; s++)
            exp_q.push_back(ent(3'(s + 1), 32'h100 * s + r, 2'(s)));
      for (int s = 0; s < 3; s++) k[s] = 0;
      bus.src0_tag = 3'd1; bus.src1_tag = 3'd2; bus.src2_tag = 3'd3;
      bus.src0_data = 32'h000; bus.src1_data = 32'h100; bus.src2_data = 32'h200;
      bus.src_valid = 3'b111;
      for (int n = 0; n < 20 && bus.src_valid != 3'b000; n++) begin
         @(negedge clk);
         smp = bus.src_ready;
         if (n < 7) chk("contention_ready", 64'(smp), 64'(rdy_tab[n]));
         step();
         for (int s = 0; s < 3; s++)
            if (bus.src_valid[s] && smp[s]) k[s]++;
         bus.src_valid = {k[2] < 3, k[1] < 3, k[0] < 3};
         bus.src0_data = 32'(k[0]);
         bus.src1_data = 32'h100 + 32'(k[1]);
         bus.src2_data = 32'h200 + 32'(k[2]);
      end
      idle(8);

      // Backpressure: source 1 held off while source 0 wins
      bus.src_valid = 3'b011;
      bus.src0_tag = 3'd6; bus.src0_data = 32'h60;
      bus.src1_tag = 3'd7; bus.src1_data = 32'h70;
      exp_q.push_back(ent(3'd6, 32'h60, 2'd0));
      exp_q.push_back(ent(3'd7, 32'h70, 2'd1));
      exp_q.push_back(ent(3'd1, 32'h71, 2'd1));
      @(negedge clk);
      chk("bp_ready_both", 64'(bus.src_ready[1:0]), 64'd3);
      step();
      bus.src_valid = 3'b010; bus.src1_tag = 3'd1; bus.src1_data = 32'h71;
      @(negedge clk);
      chk("bp_ready_blocked", 64'(bus.src_ready[1]), 64'd0);
      step();
      @(negedge clk);
      chk("bp_ready_grant", 64'(bus.src_ready[1]), 64'd1);
      step();
      idle(4);

      // Same-cycle refill: source 2 streams tags 4..7
      for (int t = 4; t < 8; t++) begin
         bus.src_valid = 3'b100; bus.src2_tag = 3'(t); bus.src2_data = 32'h200 + 32'(t);
         exp_q.push_back(ent(3'(t), 32'h200 + 32'(t), 2'd2));
         @(negedge clk);
         chk("refill_ready2", 64'(bus.src_ready[2]), 64'd1);
         step();
      end
      idle(4);

      // Flush with all buffers full; offer during flush is dropped
      bus.src_valid = 3'b111;
      bus.src0_tag = 3'd3; bus.src0_data = 32'hF0;
      bus.src1_tag = 3'd4; bus.src1_data = 32'hF1;
      bus.src2_tag = 3'd5; bus.src2_data = 32'hF2;
      @(negedge clk);
      chk("fill_ready", 64'(bus.src_ready), 64'd7);
      step();
      bus.src_valid = 3'b000;
      exp_q.push_back(ent(3'd3, 32'hF0, 2'd0));
      step();
      bus.flush = 1'b1;
      bus.src_valid = 3'b100; bus.src2_tag = 3'd7; bus.src2_data = 32'hF7;
      @(negedge clk);
      chk("flush_ready", 64'(bus.src_ready), 64'd0);
      step();
      bus.flush = 1'b0;
      bus.src_valid = 3'b011;
      bus.src0_tag = 3'd6; bus.src0_data = 32'hF6;
      bus.src1_tag = 3'd0; bus.src1_data = 32'h0;
      exp_q.push_back(ent(3'd0, 32'h0, 2'd1));
      exp_q.push_back(ent(3'd6, 32'hF6, 2'd0));
      @(negedge clk);
      chk("post_flush_cdb_valid", 64'(bus.cdb_valid), 64'd0);
      step();
      idle(5);

      // Async reset while broadcasting; buffered source 2 result must be lost
      bus.src_valid = 3'b110;
      bus.src1_tag = 3'd2; bus.src1_data = 32'h33;
      bus.src2_tag = 3'd3; bus.src2_data = 32'h44;
      step();
      bus.src_valid = 3'b000;
      step();
      chk("pre_reset_cdb_valid", 64'(bus.cdb_valid), 64'd1);
      chk("pre_reset_cdb_tag",   64'(bus.cdb_tag),   64'd2);
      #1 rst_n = 1'b0;
      #1;
      chk("async_reset_drop",  64'(bus.cdb_valid), 64'd0);
      chk("reset_src_ready",   64'(bus.src_ready), 64'd0);
      #5 rst_n = 1'b1;
      step();
      bus.src_valid = 3'b101;
      bus.src0_tag = 3'd1; bus.src0_data = 32'h55;
      bus.src2_tag = 3'd4; bus.src2_data = 32'h66;
      exp_q.push_back(ent(3'd1, 32'h55, 2'd0));
      exp_q.push_back(ent(3'd4, 32'h66, 2'd2));
      step();
      idle(6);

      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
